// File: rtl/multibyte_instruction_register.sv
// Assembles a NUM_BYTES x BYTE_W instruction from sequential or addressed byte writes; inst_valid rises one cycle after the last byte.
// Backpressure: writes to a FULL register with inst_ready low are dropped and flagged on err_ovf; consume plus write starts the new instruction.
module multibyte_instruction_register #(
  parameter int BYTE_W    = 8,
  parameter int NUM_BYTES = 2,
  parameter int ENDIAN    = 0,
  parameter int SEL_W     = $clog2(NUM_BYTES),
  parameter int CNT_W     = $clog2(NUM_BYTES + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        E,
  input  logic                        auto_seq,
  input  logic [SEL_W-1:0]            sel,
  input  logic [BYTE_W-1:0]           I,
  output logic [BYTE_W*NUM_BYTES-1:0] Q,
  output logic                        inst_valid,
  input  logic                        inst_ready,
  output logic [CNT_W-1:0]            byte_cnt,
  output logic                        err_ovf
);

  localparam int INSTR_W = BYTE_W * NUM_BYTES;

  logic [NUM_BYTES-1:0] mask;
  logic [NUM_BYTES-1:0] base_mask;
  logic [NUM_BYTES-1:0] mask_nxt;
  logic [CNT_W-1:0]     base_cnt;
  logic [CNT_W-1:0]     cnt_nxt;
  logic [CNT_W-1:0]     cnt_inc;
  logic [INSTR_W-1:0]   q_nxt;
  logic                 consume;
  logic                 base_full;
  logic                 slot_ok;
  logic                 do_write;
  logic                 err_nxt;
  int                   slot_i;

  // A consume on this edge empties the register first, so a coincident write lands in the new instruction.
  always_comb begin
    consume   = inst_valid & inst_ready;
    base_mask = consume ? '0 : mask;
    base_cnt  = consume ? '0 : byte_cnt;
    base_full = &base_mask;

    if (auto_seq) begin
      slot_i  = (ENDIAN != 0) ? (NUM_BYTES - 1 - int'(base_cnt)) : int'(base_cnt);
      slot_ok = int'(base_cnt) < NUM_BYTES;
    end else begin
      slot_i  = int'(sel);
      slot_ok = int'(sel) < NUM_BYTES;
    end

    do_write = E & slot_ok & ~base_full;
    err_nxt  = E & (~slot_ok | base_full);

    q_nxt    = Q;
    mask_nxt = base_mask;
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (do_write && (slot_i == b)) begin
        q_nxt[b*BYTE_W +: BYTE_W] = I;
        mask_nxt[b]               = 1'b1;
      end
    end

    cnt_inc = {{(CNT_W-1){1'b0}}, do_write & auto_seq};
    cnt_nxt = base_cnt + cnt_inc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Q          <= '0;
      mask       <= '0;
      byte_cnt   <= '0;
      inst_valid <= 1'b0;
      err_ovf    <= 1'b0;
    end else if (clr) begin
      Q          <= '0;
      mask       <= '0;
      byte_cnt   <= '0;
      inst_valid <= 1'b0;
      err_ovf    <= 1'b0;
    end else begin
      Q          <= q_nxt;
      mask       <= mask_nxt;
      byte_cnt   <= cnt_nxt;
      inst_valid <= &mask_nxt;
      err_ovf    <= err_nxt;
    end
  end

endmodule
